// File: rtl/dino_pkg.sv
// Shared encodings and default pacing constants for the dino game control blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } ctrl_state_e;

    localparam int DEF_ACC_W     = 8;
    localparam int DEF_BASE_INC  = 128;
    localparam int DEF_LEVEL_INC = 16;
    localparam int DEF_MAX_LEVEL = 7;
    localparam int LEVEL_W       = 3;

    // Accumulator increment for a given speed level.
    function automatic int step_inc(input int base_inc, input int level_inc, input int level);
        return base_inc + level * level_inc;
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator: adds inc on each enabled cycle and emits the carry-out as a 1-cycle pulse.
// Latency: carry is registered, high the cycle after the enabled add that overflowed.
// Backpressure: none; en gates the add, clr/rst zero the phase and drop a pending carry.
module phase_accumulator #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic [ACC_W-1:0] acc,
    output logic             carry
);

    logic [ACC_W-1:0] acc_q;
    logic             carry_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (en) begin
            acc_q   <= sum[ACC_W-1:0];
            carry_q <= sum[ACC_W];
        end else begin
            carry_q <= 1'b0;
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;

endmodule

// File: rtl/obstacle_speed_ctrl.sv
// Turns the 60 Hz frame tick into a score-dependent obstacle step pulse and tracks game state.
// Latency: obstacle_tick one cycle after the frame tick; all outputs registered.
// Backpressure: none; frame ticks arriving outside RUN (or while frozen) are ignored.
module obstacle_speed_ctrl
    import dino_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int BASE_INC  = DEF_BASE_INC,
    parameter int LEVEL_INC = DEF_LEVEL_INC,
    parameter int MAX_LEVEL = DEF_MAX_LEVEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick_60hz,
    input  logic        game_start_pulse,
    input  logic        game_frozen,
    input  logic [15:0] score,
    output logic        obstacle_tick,
    output logic [2:0]  speed_level,
    output logic        level_up_pulse,
    output logic [1:0]  ctrl_state
);

    ctrl_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [3:0]         prev_hund_q, prev_hund_d;
    logic               lvl_pulse_q, lvl_pulse_d;

    logic               acc_clr;
    logic               acc_en;
    logic               run_active;
    logic [3:0]         hund;
    logic [ACC_W-1:0]   inc;
    logic [ACC_W-1:0]   phase_acc;
    logic               carry;
    logic               unused_bits;

    assign hund        = score[11:8];
    assign run_active  = (state_q == ST_RUN) && !game_frozen;
    // Built from the current level, so a tick in the same cycle as a level change uses the old rate.
    assign inc         = ACC_W'(step_inc(BASE_INC, LEVEL_INC, int'(level_q)));
    assign unused_bits = ^{score[15:12], score[7:0], phase_acc};

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        prev_hund_d = prev_hund_q;
        lvl_pulse_d = 1'b0;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;

        if (game_start_pulse) begin
            state_d     = ST_RUN;
            level_d     = '0;
            prev_hund_d = hund;
            acc_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  if (game_frozen) state_d = ST_OVER;
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_IDLE;
            endcase

            if (run_active) begin
                acc_en = game_tick_60hz;
                // Any digit change counts, including the 9->0 wrap at 1000.
                if (hund != prev_hund_q) begin
                    prev_hund_d = hund;
                    if (level_q < LEVEL_W'(MAX_LEVEL)) begin
                        level_d     = level_q + LEVEL_W'(1);
                        lvl_pulse_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            prev_hund_q <= '0;
            lvl_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            prev_hund_q <= prev_hund_d;
            lvl_pulse_q <= lvl_pulse_d;
        end
    end

    phase_accumulator #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .en    (acc_en),
        .inc   (inc),
        .acc   (phase_acc),
        .carry (carry)
    );

    assign obstacle_tick  = carry;
    assign speed_level    = level_q;
    assign level_up_pulse = lvl_pulse_q;
    assign ctrl_state     = state_q;

endmodule

// File: tb/tb_obstacle_speed_ctrl.sv
// Directed bench for obstacle_speed_ctrl with hand-computed tick and level expectations.
module tb_obstacle_speed_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_tick_60hz;
    logic        game_start_pulse;
    logic        game_frozen;
    logic [15:0] score;
    logic        obstacle_tick;
    logic [2:0]  speed_level;
    logic        level_up_pulse;
    logic [1:0]  ctrl_state;

    int n_checks = 0;
    int n_fail   = 0;
    int lvl_ups  = 0;
    int stray    = 0;

    obstacle_speed_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .game_tick_60hz   (game_tick_60hz),
        .game_start_pulse (game_start_pulse),
        .game_frozen      (game_frozen),
        .score            (score),
        .obstacle_tick    (obstacle_tick),
        .speed_level      (speed_level),
        .level_up_pulse   (level_up_pulse),
        .ctrl_state       (ctrl_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (level_up_pulse) lvl_ups++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame: tick for a cycle, report whether the step pulse followed, and flag any late pulse.
    task automatic frame(output bit t);
        game_tick_60hz = 1'b1;
        cyc();
        game_tick_60hz = 1'b0;
        t = obstacle_tick;
        cyc();
        if (obstacle_tick) stray++;
        cyc();
        if (obstacle_tick) stray++;
    endtask

    task automatic frames(input int n, output int ticks);
        bit t;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            frame(t);
            ticks += int'(t);
        end
    endtask

    task automatic start_game();
        game_start_pulse = 1'b1;
        cyc();
        game_start_pulse = 1'b0;
    endtask

    task automatic set_score(input logic [15:0] s);
        score = s;
        cyc();
        cyc();
    endtask

    initial begin
        int  tks;
        int  perr;
        bit  t;
        logic [15:0] s;

        rst = 1'b1;
        game_tick_60hz = 1'b0;
        game_start_pulse = 1'b0;
        game_frozen = 1'b0;
        score = 16'h0000;

        // T1 reset
        cyc();
        cyc();
        check("rst_state", int'(ctrl_state), 0);
        check("rst_level", int'(speed_level), 0);
        check("rst_tick", int'(obstacle_tick), 0);
        check("rst_lvlup", int'(level_up_pulse), 0);
        rst = 1'b0;
        stray = 0;
        frames(10, tks);
        check("idle_ticks", tks + stray, 0);
        check("idle_state", int'(ctrl_state), 0);

        // T2 base rate: inc 128 ticks on every second frame
        start_game();
        check("start_state", int'(ctrl_state), 1);
        check("start_level", int'(speed_level), 0);
        tks = 0;
        perr = 0;
        stray = 0;
        for (int i = 0; i < 60; i++) begin
            frame(t);
            tks += int'(t);
            if (t != (i % 2 == 1)) perr++;
        end
        check("base_ticks", tks, 30);
        check("base_pattern_err", perr, 0);
        check("base_stray", stray, 0);

        // T3 ramp at the first hundreds change
        set_score(16'h0099);
        check("no_lvl_099", int'(speed_level), 0);
        lvl_ups = 0;
        score = 16'h0100;
        cyc();
        check("ramp_pulse", int'(level_up_pulse), 1);
        check("ramp_level", int'(speed_level), 1);
        cyc();
        check("ramp_pulse_end", int'(level_up_pulse), 0);
        frames(16, tks);
        check("lvl1_ticks", tks, 9);
        check("ramp_pulses", lvl_ups, 1);

        // 9 -> 0 wrap at 1000 must count as a change
        score = 16'h0900;
        start_game();
        check("wrap_start_level", int'(speed_level), 0);
        lvl_ups = 0;
        set_score(16'h1000);
        check("wrap_level", int'(speed_level), 1);
        check("wrap_pulses", lvl_ups, 1);

        // T4 saturation
        score = 16'h0000;
        start_game();
        lvl_ups = 0;
        for (int k = 1; k <= 9; k++) begin
            s = 16'(k) << 8;
            set_score(s);
            if (k == 7) check("sat_level_at7", int'(speed_level), 7);
        end
        set_score(16'h1000);
        check("sat_level", int'(speed_level), 7);
        check("sat_pulses", lvl_ups, 7);
        frames(16, tks);
        check("lvl7_ticks", tks, 15);

        // T5 freeze / restart
        frame(t);
        check("pre_freeze_tick", int'(t), 0);
        check("pre_freeze_acc", int'(dut.u_phase_acc.acc_q), 240);
        game_frozen = 1'b1;
        frame(t);
        check("freeze_tick", int'(t), 0);
        check("freeze_state", int'(ctrl_state), 2);
        lvl_ups = 0;
        stray = 0;
        score = 16'h0100;
        frames(20, tks);
        check("over_ticks", tks + stray, 0);
        check("over_acc", int'(dut.u_phase_acc.acc_q), 240);
        check("over_level", int'(speed_level), 7);
        check("over_pulses", lvl_ups, 0);
        game_frozen = 1'b0;
        score = 16'h0000;
        game_start_pulse = 1'b1;
        game_tick_60hz = 1'b1;
        cyc();
        game_start_pulse = 1'b0;
        game_tick_60hz = 1'b0;
        check("restart_state", int'(ctrl_state), 1);
        check("restart_level", int'(speed_level), 0);
        check("restart_acc", int'(dut.u_phase_acc.acc_q), 0);
        check("restart_tick0", int'(obstacle_tick), 0);
        cyc();
        check("restart_tick1", int'(obstacle_tick), 0);
        frame(t);
        check("restart_f1", int'(t), 0);
        frame(t);
        check("restart_f2", int'(t), 1);

        // T6 rst mid-RUN at level 3 drops the in-flight tick
        set_score(16'h0100);
        set_score(16'h0200);
        set_score(16'h0300);
        check("l3_level", int'(speed_level), 3);
        frame(t);
        check("l3_f1", int'(t), 0);
        rst = 1'b1;
        game_tick_60hz = 1'b1;
        cyc();
        game_tick_60hz = 1'b0;
        check("midrst_tick", int'(obstacle_tick), 0);
        check("midrst_state", int'(ctrl_state), 0);
        check("midrst_level", int'(speed_level), 0);
        check("midrst_acc", int'(dut.u_phase_acc.acc_q), 0);
        cyc();
        check("midrst_tick_late", int'(obstacle_tick), 0);
        rst = 1'b0;
        start_game();
        frame(t);
        check("post_rst_f1", int'(t), 0);
        frame(t);
        check("post_rst_f2", int'(t), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
